// File: rtl/lfsr_checker.sv
// ============================================================================
// lfsr_checker: locks onto an 8-bit XNOR-LFSR stream and counts mismatches.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lfsr_checker #(
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             enable,
  input  logic [7:0]       data_in,
  input  logic             clear_count,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       expected
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MATCH_W-1:0] c_lock_count  = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  c_unlock_errs = MISS_W'(UNLOCK_ERRS);
  localparam logic [7:0]         c_lockup      = 8'hFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], ~(x[7] ^ x[2])};
  endfunction

  state_t             state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [7:0]         expected_q, expected_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;

  logic [MATCH_W-1:0] match_inc;
  logic [MISS_W-1:0]  miss_inc;

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    miss_d      = miss_q;
    expected_d  = expected_q;
    err_count_d = err_count_q;
    locked_d    = locked_q;
    error_d     = 1'b0;
    match_inc   = match_q + MATCH_W'(1);
    miss_inc    = miss_q + MISS_W'(1);

    if (enable) begin
      case (state_q)
        HUNT: begin
          // FF is the XNOR lock-up value; seeding from it would never advance
          if (data_in != c_lockup) begin
            expected_d = lfsr_next(data_in);
            match_d    = '0;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          expected_d = lfsr_next(data_in);
          if (data_in == expected_q) begin
            match_d = match_inc;
            if (match_inc == c_lock_count) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction never re-seeds from the received data
          expected_d = lfsr_next(expected_q);
          if (data_in == expected_q) begin
            miss_d = '0;
          end else begin
            error_d = 1'b1;
            miss_d  = miss_inc;
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (miss_inc == c_unlock_errs) begin
              state_d  = HUNT;
              locked_d = 1'b0;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end

    // Clear takes priority over a coincident increment
    if (clear_count) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= HUNT;
      match_q     <= '0;
      miss_q      <= '0;
      expected_q  <= 8'h00;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  assign locked    = locked_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_checker.sv
// ============================================================================
// tb_lfsr_checker: two checker configurations against a bench-side model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  logic        lk0, er0, lk1, er1;
  logic [15:0] ec0;
  logic [1:0]  ec1;
  logic [7:0]  ex0, ex1;

  lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_ERRS(3), .CNT_W(16)) u_dut0 (
    .Clk(clk), .Reset(rst), .enable(en), .data_in(din), .clear_count(clr),
    .locked(lk0), .error(er0), .err_count(ec0), .expected(ex0)
  );

  lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_ERRS(8), .CNT_W(2)) u_dut1 (
    .Clk(clk), .Reset(rst), .enable(en), .data_in(din), .clear_count(clr),
    .locked(lk1), .error(er1), .err_count(ec1), .expected(ex1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] nx(input logic [7:0] x);
    return {x[6:0], ~(x[7] ^ x[2])};
  endfunction

  // Reference model, one slot per instance; mode 0=hunt, 1=verify, 2=locked
  int         lock_need[2] = '{4, 4};
  int         unlock_at[2] = '{3, 8};
  int         cnt_max[2]   = '{65535, 3};
  int         m_mode[2], m_match[2], m_miss[2], m_cnt[2];
  logic [7:0] m_pred[2];
  bit         m_lk[2], m_err[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] <= 0; m_match[i] <= 0; m_miss[i] <= 0; m_cnt[i] <= 0;
        m_pred[i] <= 8'h00; m_lk[i] <= 1'b0; m_err[i] <= 1'b0;
      end else begin
        automatic int         mode = m_mode[i];
        automatic int         mt   = m_match[i];
        automatic int         ms   = m_miss[i];
        automatic int         cnt  = m_cnt[i];
        automatic logic [7:0] pred = m_pred[i];
        automatic bit         lk   = m_lk[i];
        automatic bit         er   = 1'b0;
        if (en) begin
          if (mode == 0) begin
            if (din != 8'hFF) begin pred = nx(din); mt = 0; mode = 1; end
          end else if (mode == 1) begin
            if (din == pred) begin
              mt++;
              if (mt == lock_need[i]) begin mode = 2; lk = 1'b1; ms = 0; end
            end else begin
              mt = 0;
            end
            pred = nx(din);
          end else begin
            er   = (din != pred);
            pred = nx(pred);
            if (er) begin
              if (cnt < cnt_max[i]) cnt++;
              ms++;
              if (ms == unlock_at[i]) begin mode = 0; lk = 1'b0; end
            end else begin
              ms = 0;
            end
          end
        end
        if (clr) cnt = 0;
        m_mode[i] <= mode; m_match[i] <= mt; m_miss[i] <= ms; m_cnt[i] <= cnt;
        m_pred[i] <= pred; m_lk[i] <= lk; m_err[i] <= er;
      end
    end
  end

  always @(negedge clk) begin
    check("d0_locked",    {31'd0, lk0}, {31'd0, m_lk[0]});
    check("d0_error",     {31'd0, er0}, {31'd0, m_err[0]});
    check("d0_err_count", {16'd0, ec0}, m_cnt[0]);
    check("d0_expected",  {24'd0, ex0}, {24'd0, m_pred[0]});
    check("d1_locked",    {31'd0, lk1}, {31'd0, m_lk[1]});
    check("d1_error",     {31'd0, er1}, {31'd0, m_err[1]});
    check("d1_err_count", {30'd0, ec1}, m_cnt[1]);
    check("d1_expected",  {24'd0, ex1}, {24'd0, m_pred[1]});
  end

  task automatic drv(input logic e, input logic [7:0] d, input logic c);
    @(negedge clk);
    en = e; din = d; clr = c;
  endtask

  task automatic gap();
    drv(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] d);
    drv(1'b1, d, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic lock_seq();
    send(8'h00); send(8'h01); send(8'h03); send(8'h07); send(8'h0E);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_locked",   {31'd0, lk0}, 32'd0);
    check("rst_error",    {31'd0, er0}, 32'd0);
    check("rst_count",    {16'd0, ec0}, 32'd0);
    check("rst_expected", {24'd0, ex0}, 32'h00);
    #2 rst = 1'b0;

    // Lock from seed 00
    lock_seq();
    gap();
    check("lock_locked",   {31'd0, lk0}, 32'd1);
    check("lock_expected", {24'd0, ex0}, 32'h1C);
    check("lock_count",    {16'd0, ec0}, 32'd0);

    // Single corruption, then a correct value
    send(8'h1D);
    gap();
    check("corrupt_error",    {31'd0, er0}, 32'd1);
    check("corrupt_count",    {16'd0, ec0}, 32'd1);
    check("corrupt_expected", {24'd0, ex0}, 32'h38);
    send(8'h38);
    gap();
    check("resume_expected", {24'd0, ex0}, 32'h71);
    check("resume_locked",   {31'd0, lk0}, 32'd1);

    // Loss of lock after three consecutive misses
    drv(1'b0, 8'h00, 1'b1);
    send(8'hAA); send(8'hAA); send(8'hAA);
    gap();
    check("unlock_error",  {31'd0, er0}, 32'd1);
    check("unlock_count",  {16'd0, ec0}, 32'd3);
    check("unlock_locked", {31'd0, lk0}, 32'd0);
    lock_seq();
    gap();
    check("relock_locked", {31'd0, lk0}, 32'd1);

    // Lock-up value in HUNT, then enable gaps during VERIFY
    pulse_reset();
    send(8'hFF);
    gap();
    check("ff_expected", {24'd0, ex0}, 32'h00);
    send(8'h01);
    gap(); gap();
    check("gap_expected", {24'd0, ex0}, 32'h03);
    send(8'h03);
    gap(); gap();
    send(8'h07); send(8'h0E); send(8'h1C);
    gap();
    check("gap_locked", {31'd0, lk0}, 32'd1);

    // Saturation on the 2-bit counter instance
    for (int k = 0; k < 5; k++) begin
      send(8'hAA);
      gap();
      check("sat_count", {30'd0, ec1}, (k < 3) ? k + 1 : 3);
    end
    drv(1'b1, 8'hAA, 1'b1);
    gap();
    check("clr_count",  {30'd0, ec1}, 32'd0);
    check("clr_error",  {31'd0, er1}, 32'd1);
    check("clr_locked", {31'd0, lk1}, 32'd1);

    // Asynchronous reset while locked with two errors counted
    pulse_reset();
    lock_seq();
    send(8'hAA); send(8'hAA);
    gap();
    check("pre_rst_count",  {16'd0, ec0}, 32'd2);
    check("pre_rst_locked", {31'd0, lk0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_locked",   {31'd0, lk0}, 32'd0);
    check("async_count",    {16'd0, ec0}, 32'd0);
    check("async_expected", {24'd0, ex0}, 32'h00);
    #1 rst = 1'b0;
    gap(); gap();
    check("post_rst_error", {31'd0, er0}, 32'd0);
    send(8'h00);
    gap();
    check("post_rst_expected", {24'd0, ex0}, 32'h01);
    check("post_rst_locked",   {31'd0, lk0}, 32'd0);
    gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
